// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank: bus writes through a pointer byte, sequential reads,
// open-drain SDA via output enable, plus a combinational debug read port.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned NREGS    = 16,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  output logic          busy_o,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [7:0]    dbg_data_o
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdMack, StIgnore
  } state_e;

  logic          r_scl_s1, r_scl_s2, r_scl_h;
  logic          r_sda_s1, r_sda_s2, r_sda_h;
  state_e        r_state, w_state_nx;
  logic [2:0]    r_cnt, w_cnt_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [AW-1:0] r_ptr, w_ptr_nx;
  logic          r_sda_oe, w_oe_nx;
  logic          r_busy, w_busy_nx;
  logic          r_rw, w_rw_nx;
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_regs [NREGS];
  logic          w_we;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
  assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
  assign w_byte     = {r_shift[6:0], r_sda_s2};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_ptr_nx   = r_ptr;
    w_oe_nx    = r_sda_oe;
    w_busy_nx  = r_busy;
    w_rw_nx    = r_rw;
    w_we       = 1'b0;
    if (w_start) begin
      w_state_nx = StAddr;
      w_cnt_nx   = 3'd0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else if (w_stop) begin
      w_state_nx = StIdle;
      w_cnt_nx   = 3'd0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else begin
      unique case (r_state)
        StAddr, StPtr, StWdata: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              unique case (r_state)
                StAddr: begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    w_busy_nx  = 1'b1;
                    w_rw_nx    = w_byte[0];
                    w_state_nx = StAddrAck;
                  end else begin
                    w_state_nx = StIgnore;
                  end
                end
                StPtr: begin
                  w_ptr_nx   = w_byte[AW-1:0];
                  w_state_nx = StPtrAck;
                end
                default: begin
                  w_we       = 1'b1;
                  w_ptr_nx   = r_ptr + AW'(1);
                  w_state_nx = StWdataAck;
                end
              endcase
            end
          end
        end
        // First fall drives the ACK low, the second releases it (or starts the read byte).
        StAddrAck: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nx = 1'b1;
            end else if (r_rw) begin
              w_shift_nx = {r_regs[r_ptr][6:0], 1'b0};
              w_oe_nx    = ~r_regs[r_ptr][7];
              w_cnt_nx   = 3'd0;
              w_state_nx = StRdata;
            end else begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 3'd0;
              w_state_nx = StPtr;
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nx = 1'b1;
            end else begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 3'd0;
              w_state_nx = StWdata;
            end
          end
        end
        StRdata: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 3'd0;
              w_state_nx = StRdMack;
            end else begin
              w_oe_nx    = ~r_shift[7];
              w_shift_nx = {r_shift[6:0], 1'b0};
              w_cnt_nx   = r_cnt + 3'd1;
            end
          end
        end
        // r_cnt == 1 marks a master ACK awaiting the fall that launches the next byte.
        StRdMack: begin
          if (w_scl_rise) begin
            w_ptr_nx = r_ptr + AW'(1);
            if (r_sda_s2) w_state_nx = StIgnore;
            else          w_cnt_nx   = 3'd1;
          end else if (w_scl_fall && r_cnt == 3'd1) begin
            w_shift_nx = {r_regs[r_ptr][6:0], 1'b0};
            w_oe_nx    = ~r_regs[r_ptr][7];
            w_cnt_nx   = 3'd0;
            w_state_nx = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_shift    <= 8'h00;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_i, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_i, r_sda_s1, r_sda_s2};
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_ptr      <= w_ptr_nx;
      r_sda_oe   <= w_oe_nx;
      r_busy     <= w_busy_nx;
      r_rw       <= w_rw_nx;
      r_wr_valid <= w_we;
      if (w_we) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_addr     <= r_ptr;
        r_wr_data     <= w_byte;
      end
    end
  end

  assign sda_oe_o   = r_sda_oe;
  assign busy_o     = r_busy;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign dbg_data_o = r_regs[dbg_addr_i];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against an array model of the bank.
module tb_i2c_target_regs;
  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int Q     = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_scl, m_sda;
  logic          scl_i, sda_i;
  logic          sda_oe_o, busy_o, wr_valid_o;
  logic [AW-1:0] wr_addr_o, dbg_addr;
  logic [7:0]    wr_data_o, dbg_data_o;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe_o;

  i2c_target_regs #(.DEV_ADDR(7'h50), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe_o(sda_oe_o), .busy_o(busy_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0]      m_regs [NREGS];
  int              m_ptr;
  logic [7:0]      tx_q[$];
  logic [AW+7:0]   wr_log[$];
  int              oe_cnt = 0;
  int              busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_valid_o) wr_log.push_back({wr_addr_o, wr_data_o});
    if (sda_oe_o) oe_cnt++;
    if (busy_o) busy_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q(); m_sda = 1'b0; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q(); m_scl = 1'b1; wait_q(); m_sda = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; wait_q(); m_scl = 1'b1; wait_q(); wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic put_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q(); acked = ~sda_i; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] b, output logic oe_mack);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q(); m_scl = 1'b1; wait_q(); b[i] = sda_i; wait_q(); m_scl = 1'b0; wait_q();
    end
    m_sda = nack; wait_q(); m_scl = 1'b1; wait_q(); oe_mack = sda_oe_o; wait_q(); m_scl = 1'b0;
    wait_q(); m_sda = 1'b1;
  endtask

  task automatic check_dbg_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if (dbg_data_o !== m_regs[i])
        $display("FAIL %s dbg[%0d]: got %h want %h", tag, i, dbg_data_o, m_regs[i]);
      else n_pass++;
    end
  endtask

  // Writes tx_q starting at register idx (idx may exceed NREGS; upper bits must be ignored).
  task automatic do_write(input int idx, input string tag);
    logic ack;
    int base;
    logic [AW+7:0] exp[$];
    base = wr_log.size();
    bus_start();
    put_byte(8'hA0, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL %s addr_ack: got %b want 1", tag, ack); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL %s busy: got %b want 1", tag, busy_o); else n_pass++;
    put_byte(8'(idx), ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL %s ptr_ack: got %b want 1", tag, ack); else n_pass++;
    m_ptr = idx % NREGS;
    foreach (tx_q[k]) begin
      put_byte(tx_q[k], ack);
      n_checks++;
      if (ack !== 1'b1) $display("FAIL %s data_ack[%0d]: got %b want 1", tag, k, ack); else n_pass++;
      m_regs[m_ptr] = tx_q[k];
      exp.push_back({AW'(m_ptr), tx_q[k]});
      m_ptr = (m_ptr + 1) % NREGS;
    end
    bus_stop();
    repeat (6) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL %s busy_after_stop: got %b want 0", tag, busy_o);
    else n_pass++;
    n_checks++;
    if (wr_log.size() - base != exp.size())
      $display("FAIL %s wr_count: got %0d want %0d", tag, wr_log.size() - base, exp.size());
    else begin
      n_pass++;
      foreach (exp[k]) begin
        n_checks++;
        if (wr_log[base + k] !== exp[k])
          $display("FAIL %s wr[%0d]: got %h want %h", tag, k, wr_log[base + k], exp[k]);
        else n_pass++;
      end
    end
  endtask

  // Reads n bytes (ACK all but the last), optionally setting the pointer first with Sr.
  task automatic do_read(input bit set_ptr, input int idx, input int n, input string tag);
    logic ack, oe_m;
    logic [7:0] b;
    int base;
    base = wr_log.size();
    bus_start();
    if (set_ptr) begin
      put_byte(8'hA0, ack);
      n_checks++; if (ack !== 1'b1) $display("FAIL %s waddr_ack: got %b want 1", tag, ack); else n_pass++;
      put_byte(8'(idx), ack);
      n_checks++; if (ack !== 1'b1) $display("FAIL %s ptr_ack: got %b want 1", tag, ack); else n_pass++;
      m_ptr = idx % NREGS;
      bus_start();
    end
    put_byte(8'hA1, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL %s raddr_ack: got %b want 1", tag, ack); else n_pass++;
    for (int k = 0; k < n; k++) begin
      get_byte(k == n - 1, b, oe_m);
      n_checks++;
      if (b !== m_regs[m_ptr]) $display("FAIL %s rd[%0d]: got %h want %h", tag, k, b, m_regs[m_ptr]);
      else n_pass++;
      n_checks++;
      if (oe_m !== 1'b0) $display("FAIL %s oe_at_mack[%0d]: got %b want 0", tag, k, oe_m);
      else n_pass++;
      m_ptr = (m_ptr + 1) % NREGS;
    end
    bus_stop();
    repeat (6) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL %s busy_after_stop: got %b want 0", tag, busy_o);
    else n_pass++;
    n_checks++;
    if (wr_log.size() != base) $display("FAIL %s no_write: got %0d want %0d", tag, wr_log.size(), base);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; dbg_addr = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (sda_oe_o !== 1'b0) $display("FAIL reset oe: got %b want 0", sda_oe_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (wr_valid_o !== 1'b0) $display("FAIL reset wr_valid: got %b want 0", wr_valid_o);
    else n_pass++;
    n_checks++; if ({wr_addr_o, wr_data_o} !== '0)
      $display("FAIL reset wr_addr/data: got %h want 0", {wr_addr_o, wr_data_o});
    else n_pass++;
    check_dbg_all("reset");
  endtask

  task automatic test_write();
    tx_q = '{8'h5A, 8'hC3};
    do_write(3, "write");
    check_dbg_all("write");
  endtask

  task automatic test_read();
    do_read(1'b1, 3, 2, "read");
  endtask

  task automatic test_wrong_addr(input logic [7:0] addr_byte, input string tag);
    logic ack;
    int oe0, busy0, wr0;
    oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_log.size();
    bus_start();
    put_byte(addr_byte, ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL %s addr_ack: got %b want 0", tag, ack); else n_pass++;
    put_byte(8'h00, ack);
    put_byte(8'hFF, ack);
    bus_stop();
    repeat (6) @(negedge clk);
    n_checks++; if (oe_cnt != oe0) $display("FAIL %s oe_cycles: got %0d want 0", tag, oe_cnt - oe0);
    else n_pass++;
    n_checks++; if (busy_cnt != busy0) $display("FAIL %s busy_cycles: got %0d want 0", tag, busy_cnt - busy0);
    else n_pass++;
    n_checks++; if (wr_log.size() != wr0) $display("FAIL %s writes: got %0d want 0", tag, wr_log.size() - wr0);
    else n_pass++;
    check_dbg_all(tag);
  endtask

  task automatic test_wrap();
    tx_q = '{8'h11, 8'h22};
    do_write(15, "wrap");
    check_dbg_all("wrap");
  endtask

  task automatic test_abort();
    logic ack;
    int oe0, wr0;
    wr0 = wr_log.size();
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'h05, ack);
    m_ptr = 5;
    oe0 = oe_cnt;
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    bus_stop();
    repeat (6) @(negedge clk);
    n_checks++; if (oe_cnt != oe0) $display("FAIL abort oe_cycles: got %0d want 0", oe_cnt - oe0); else n_pass++;
    n_checks++; if (wr_log.size() != wr0) $display("FAIL abort writes: got %0d want 0", wr_log.size() - wr0);
    else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort busy: got %b want 0", busy_o); else n_pass++;
    check_dbg_all("abort");
    tx_q = '{8'($urandom)};
    do_write(5, "after_abort");
    check_dbg_all("after_abort");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      tx_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) tx_q.push_back(8'($urandom));
      do_write(int'($urandom_range(0, 255)), "b2b_write");
    end
    check_dbg_all("b2b");
    do_read(1'b1, int'($urandom_range(0, 255)), 3, "b2b_read");
    do_read(1'b0, 0, 2, "b2b_read_cont");
  endtask

  task automatic test_reset_mid();
    logic ack;
    int idx;
    idx = int'($urandom_range(0, NREGS - 1));
    tx_q = '{8'h00};
    do_write(idx, "rmid_prep");
    bus_start();
    put_byte(8'hA0, ack);
    put_byte(8'(idx), ack);
    bus_start();
    put_byte(8'hA1, ack);
    n_checks++; if (sda_oe_o !== 1'b1) $display("FAIL rmid oe_before: got %b want 1", sda_oe_o); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (sda_oe_o !== 1'b0) $display("FAIL rmid oe: got %b want 0", sda_oe_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rmid busy: got %b want 0", busy_o); else n_pass++;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    m_sda = 1'b1; wait_q(); m_scl = 1'b1; wait_q();
    check_dbg_all("rmid");
    tx_q = '{8'($urandom)};
    do_write(int'($urandom_range(0, NREGS - 1)), "rmid_after");
    check_dbg_all("rmid_after");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr(8'hA2, "wrong_a2");
    test_wrong_addr({7'($urandom_range(0, 79)), 1'($urandom)}, "wrong_rand");
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
